// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmit FSM state encoding.
// Imported by both the transmit and receive paths.
package uart_pkg;

    localparam int   UART_DATA_W    = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the oldest entry.
// Depth is 2**AW; level carries one extra bit so a full FIFO is representable.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rdreq,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    // full/empty come from the pre-edge count, so a write while full is
    // refused even when a pop happens on the same edge.
    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];
    assign push  = wrreq && !full;
    assign pop   = rdreq && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide
    // which entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a clock-enable baud counter.
// Back-to-back frames leave no idle gap when the FIFO has data at the stop-bit wrap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wrreq,
    input  logic [UART_DATA_W-1:0] write_data,
    output logic                   full,
    output logic [FIFO_AW:0]       level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   txd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_W);
    localparam int FIFO_AW_EFF = $clog2(FIFO_DEPTH);

    tx_state_e              state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [BIT_W-1:0]       bit_idx, bit_idx_d;
    logic [UART_DATA_W-1:0] shreg, shreg_d;
    logic                   txd_d;
    logic                   pop;
    logic                   wrap;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rdata;

    uart_fifo #(
        .DATA_W (UART_DATA_W),
        .AW     (FIFO_AW_EFF)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrreq  (wrreq),
        .wdata  (write_data),
        .rdreq  (pop),
        .rdata  (fifo_rdata),
        .full   (full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign busy = (state != TX_IDLE) || !fifo_empty;
    assign wrap = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        txd_d     = txd;
        pop       = 1'b0;

        case (state)
            TX_IDLE: begin
                txd_d = UART_STOP_BIT;
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    txd_d   = UART_START_BIT;
                    state_d = TX_START;
                end
            end

            TX_START: begin
                cnt_d = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    txd_d     = shreg[0];
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end
            end

            TX_DATA: begin
                cnt_d = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    if (bit_idx == BIT_W'(UART_DATA_W - 1)) begin
                        txd_d   = UART_STOP_BIT;
                        state_d = TX_STOP;
                    end else begin
                        shreg_d   = shreg >> 1;
                        txd_d     = shreg[1];
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end

            TX_STOP: begin
                cnt_d = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        txd_d   = UART_START_BIT;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end

            default: begin
                txd_d   = UART_STOP_BIT;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= UART_STOP_BIT;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            txd     <= txd_d;
        end
    end

    // Sticky: a refused write stays visible until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (wrreq && full) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a CLKS_PER_BIT=4 instance for most scenarios and a
// CLKS_PER_BIT=2 instance for the short-bit frame.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       wrreq;
    logic [7:0] write_data;
    logic       full;
    logic [4:0] level;
    logic       busy;
    logic       overflow;
    logic       txd;

    logic       wrreq2;
    logic [7:0] write_data2;
    logic       full2;
    logic [4:0] level2;
    logic       busy2;
    logic       overflow2;
    logic       txd2;

    int n_checks;
    int n_errors;

    logic [7:0] rx;
    bit         rx_ok;

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrreq      (wrreq),
        .write_data (write_data),
        .full       (full),
        .level      (level),
        .busy       (busy),
        .overflow   (overflow),
        .txd        (txd)
    );

    uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(16), .FIFO_AW(4)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrreq      (wrreq2),
        .write_data (write_data2),
        .full       (full2),
        .level      (level2),
        .busy       (busy2),
        .overflow   (overflow2),
        .txd        (txd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compares the line every cycle against start, LSB-first data, stop.
    task automatic expect_frame(input logic [7:0] b, input int cpb, input bit use2, input string tag);
        logic exp_bit;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      exp_bit = 1'b0;
            else if (k == 9) exp_bit = 1'b1;
            else             exp_bit = b[k-1];
            for (int c = 0; c < cpb; c++) begin
                check($sformatf("%s_bit%0d_cyc%0d", tag, k, c), use2 ? txd2 : txd, exp_bit);
                tick();
            end
        end
    endtask

    // Mid-bit sampling receiver for the CLKS_PER_BIT=4 instance; returns in mid-stop.
    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int guard;
        guard = 0;
        ok    = 1'b1;
        b     = '0;
        while (txd !== 1'b0 && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) begin
            ok = 1'b0;
        end else begin
            repeat (2) tick();
            for (int i = 0; i < 8; i++) begin
                repeat (4) tick();
                b[i] = txd;
            end
            repeat (4) tick();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        wrreq       = 1'b0;
        write_data  = '0;
        wrreq2      = 1'b0;
        write_data2 = '0;
        repeat (2) @(posedge clk);
        #1;

        check("rst_txd",      txd,      1'b1);
        check("rst_full",     full,     1'b0);
        check("rst_level",    level,    5'd0);
        check("rst_busy",     busy,     1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_txd2",     txd2,     1'b1);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single 0xA5 frame from idle.
        wrreq = 1'b1; write_data = 8'hA5;
        tick();
        wrreq = 1'b0;
        check("a5_level_e0", level, 5'd1);
        check("a5_txd_e0",   txd,   1'b1);
        tick();
        check("a5_busy", busy, 1'b1);
        expect_frame(8'hA5, 4, 1'b0, "a5");
        check("a5_busy_after", busy,  1'b0);
        check("a5_txd_after",  txd,   1'b1);

        // 0x00 then 0xFF on consecutive cycles: contiguous frames.
        wrreq = 1'b1; write_data = 8'h00;
        tick();
        write_data = 8'hFF;
        tick();
        wrreq = 1'b0;
        check("b2b_level_same_edge", level, 5'd1);
        expect_frame(8'h00, 4, 1'b0, "b2b0");
        expect_frame(8'hFF, 4, 1'b0, "b2bff");
        check("b2b_level_end", level, 5'd0);
        check("b2b_busy_end",  busy,  1'b0);

        // 18 consecutive writes: 17 accepted, 18th dropped.
        fork
            begin
                for (int i = 1; i <= 18; i++) begin
                    wrreq = 1'b1; write_data = 8'(i);
                    tick();
                    if (i == 16) check("burst_full_at16", full, 1'b0);
                    if (i == 17) begin
                        check("burst_full_at17",  full,  1'b1);
                        check("burst_level_at17", level, 5'd16);
                        check("burst_ovf_at17",   overflow, 1'b0);
                    end
                end
                wrreq = 1'b0;
                check("burst_overflow", overflow, 1'b1);
                check("burst_level_18", level,    5'd16);
            end
            begin
                for (int i = 1; i <= 17; i++) begin
                    recv_byte(rx, rx_ok);
                    check($sformatf("burst_rx%0d_timeout", i), 32'(rx_ok), 32'd1);
                    check($sformatf("burst_rx%0d", i), rx, 8'(i));
                end
            end
        join
        repeat (4) tick();
        check("burst_level_end", level,    5'd0);
        check("burst_busy_end",  busy,     1'b0);
        check("burst_ovf_sticky", overflow, 1'b1);

        // Write coinciding with the pop at the stop-bit wrap, level=1.
        fork
            begin
                wrreq = 1'b1; write_data = 8'h11;
                tick();
                wrreq = 1'b0;
                repeat (4) tick();
                wrreq = 1'b1; write_data = 8'h22;
                tick();
                wrreq = 1'b0;
                check("wp_level_queued", level, 5'd1);
                repeat (35) tick();
                wrreq = 1'b1; write_data = 8'h33;
                tick();
                wrreq = 1'b0;
                check("wp_level_same_edge", level, 5'd1);
            end
            begin
                recv_byte(rx, rx_ok);
                check("wp_rx0", rx, 8'h11);
                recv_byte(rx, rx_ok);
                check("wp_rx1", rx, 8'h22);
                recv_byte(rx, rx_ok);
                check("wp_rx2_timeout", 32'(rx_ok), 32'd1);
                check("wp_rx2", rx, 8'h33);
            end
        join
        repeat (4) tick();
        check("wp_level_end", level, 5'd0);
        check("wp_busy_end",  busy,  1'b0);

        // Reset during DATA of 0x3C with 4 bytes queued.
        wrreq = 1'b1; write_data = 8'h3C;
        tick();
        for (int i = 1; i <= 4; i++) begin
            write_data = 8'(i);
            tick();
        end
        wrreq = 1'b0;
        check("rst_mid_level_pre", level, 5'd4);
        repeat (4) tick();
        check("rst_mid_txd_pre", txd, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_txd",   txd,      1'b1);
        check("rst_mid_level", level,    5'd0);
        check("rst_mid_ovf",   overflow, 1'b0);
        check("rst_mid_busy",  busy,     1'b0);
        check("rst_mid_full",  full,     1'b0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            check($sformatf("rst_idle_txd%0d", i), txd, 1'b1);
        end
        check("rst_idle_level", level, 5'd0);
        check("rst_idle_busy",  busy,  1'b0);

        // CLKS_PER_BIT=2 instance, 0x80: bit 7 is the last data bit.
        wrreq2 = 1'b1; write_data2 = 8'h80;
        tick();
        wrreq2 = 1'b0;
        check("cpb2_txd_e0", txd2, 1'b1);
        tick();
        expect_frame(8'h80, 2, 1'b1, "cpb2");
        check("cpb2_busy_end",  busy2,  1'b0);
        check("cpb2_level_end", level2, 5'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
